// File: rtl/rf_calc_engine.sv
// rf_calc_engine: small register-file / accumulator / calculator engine
// driven by debounced push-button pulses. Three modes (RF, ACC, CALC) are
// cycled with button 3. The calculator runs a short IDLE -> EXEC -> SHOW
// sequence and writes its result back into the last register-file entry.
//
// Optional feature: define RF_CALC_SATURATE_EN to clamp ACC +/- and CALC
// add/sub at the range limits instead of wrapping. The default build wraps.
module rf_calc_engine #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       buttons_pressed,
    input  logic [1:0]       switches,
    output logic [WIDTH:0]   leds,
    output logic [1:0]       mode,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        MODE_RF   = 2'd0,
        MODE_ACC  = 2'd1,
        MODE_CALC = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

    mode_e              mode_q, mode_d;
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   rf_q [DEPTH];
    logic [WIDTH-1:0]   rf_d [DEPTH];
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               carry_q, carry_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH:0]     leds_q, leds_d;
    logic               busy_q, busy_d;

    // Extended-width arithmetic: the top bit is the carry-out / borrow.
    logic [WIDTH:0]     acc_inc, acc_dec, calc_sum, calc_diff;
    logic [WIDTH-1:0]   alu_val;
    logic               alu_flag;
    logic               busy_now;
    logic               mode_btn;

    assign busy_now  = (state_q != ST_IDLE);
    // Mode advance only while idle; it also masks buttons [2:0] that cycle.
    assign mode_btn  = buttons_pressed[3] && !busy_now;

    assign acc_inc   = {1'b0, acc_q} + (WIDTH+1)'(1);
    assign acc_dec   = {1'b0, acc_q} - (WIDTH+1)'(1);
    assign calc_sum  = {1'b0, rf_q[0]} + {1'b0, rf_q[1]};
    assign calc_diff = {1'b0, rf_q[0]} - {1'b0, rf_q[1]};

    // Calculator ALU on A = rf[0], B = rf[1] using the op latched at start.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        alu_val  = '0;
        alu_flag = 1'b0;
        case (op_q)
            2'b00: begin
                alu_val  = calc_sum[WIDTH-1:0];
                alu_flag = calc_sum[WIDTH];
`ifdef RF_CALC_SATURATE_EN
                if (calc_sum[WIDTH]) alu_val = '1;
`endif
            end
            2'b01: begin
                alu_val  = calc_diff[WIDTH-1:0];
                alu_flag = calc_diff[WIDTH];
`ifdef RF_CALC_SATURATE_EN
                if (calc_diff[WIDTH]) alu_val = '0;
`endif
            end
            2'b10:   alu_val = rf_q[0] & rf_q[1];
            default: alu_val = rf_q[0] ^ rf_q[1];
        endcase
    end

    // Calculator FSM next state: start on btn0 in CALC mode, then two fixed steps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mode_q == MODE_CALC && !mode_btn && buttons_pressed[0])
                         state_d = ST_EXEC;
            ST_EXEC: state_d = ST_SHOW;
            default: state_d = ST_IDLE;
        endcase
    end

    // Calculator FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath next state: mode cycling, per-mode button actions, result write-back.
    always_comb begin
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        rf_d    = rf_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        carry_d = carry_q;
        op_d    = op_q;

        if (mode_btn) begin
            case (mode_q)
                MODE_RF:  mode_d = MODE_ACC;
                MODE_ACC: mode_d = MODE_CALC;
                default:  mode_d = MODE_RF;
            endcase
        end else if (!busy_now) begin
            case (mode_q)
                MODE_RF: begin
                    if (buttons_pressed[2])
                        rf_d[ptr_q] = rf_q[ptr_q] - WIDTH'(1);
                    else if (buttons_pressed[1])
                        rf_d[ptr_q] = rf_q[ptr_q] + WIDTH'(1);
                    else if (buttons_pressed[0])
                        ptr_d = ptr_q + PTR_W'(1);
                end
                MODE_ACC: begin
                    if (buttons_pressed[2]) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end else if (buttons_pressed[1]) begin
                        acc_d = acc_dec[WIDTH-1:0];
                        if (acc_dec[WIDTH]) begin
                            ovf_d = 1'b1;
`ifdef RF_CALC_SATURATE_EN
                            acc_d = '0;
`endif
                        end
                    end else if (buttons_pressed[0]) begin
                        acc_d = acc_inc[WIDTH-1:0];
                        if (acc_inc[WIDTH]) begin
                            ovf_d = 1'b1;
`ifdef RF_CALC_SATURATE_EN
                            acc_d = '1;
`endif
                        end
                    end
                end
                default: begin
                    if (buttons_pressed[0]) op_d = switches;
                end
            endcase
        end

        if (state_q == ST_EXEC) begin
            res_d           = alu_val;
            carry_d         = alu_flag;
            rf_d[DEPTH-1]   = alu_val;
        end
    end

    // Display value for the current mode, registered one cycle later.
    always_comb begin
        leds_d = '0;
        case (mode_q)
            MODE_RF:   leds_d = {1'b0, rf_q[ptr_q]};
            MODE_ACC:  leds_d = {ovf_q, acc_q};
            MODE_CALC: leds_d = {carry_q, res_q};
            default:   leds_d = '0;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_RF;
            ptr_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            // NOTE: the register file is a handful of flops that must read zero after reset, so it is reset explicitly.
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else begin
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign leds = leds_q;
    assign mode = mode_q;
    assign busy = busy_q;

endmodule
